fpu_sp_operand_queue: RTL and testbench
=======================================

FPU_SP_OPERAND_QUEUE -- requirements
Module: fpu_sp_operand_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, operand-pair FIFO entries; power of two, >= 2.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  upstream operand pair valid.
REQ-005 SHALL have port in_ready  output  1  queue can accept a pair.
REQ-006 SHALL have port in_a  input  32  IEEE-754 single operand A.
REQ-007 SHALL have port in_b  input  32  IEEE-754 single operand B.
REQ-008 SHALL have port add_a  output  32  operand A to fpu_sp_adder a.
REQ-009 SHALL have port add_b  output  32  operand B to fpu_sp_adder b.
REQ-010 SHALL have port add_result  input  32  from fpu_sp_adder result.
REQ-011 SHALL have port add_ovf  input  1  from fpu_sp_adder overflow_underflow_flag.
REQ-012 SHALL have port out_valid  output  1  registered result valid.
REQ-013 SHALL have port out_ready  input  1  downstream accepts result.
REQ-014 SHALL have port out_result  output  32  registered sum.
REQ-015 SHALL have port out_ovf  output  1  registered overflow/underflow flag of out_result.
REQ-016 SHALL have port count  output  log2(DEPTH)+1  FIFO occupancy.
REQ-017 SHALL have port sticky_ovf  output  1  accumulated overflow/underflow flag.
REQ-018 SHALL have port clear_sticky  input  1  synchronous clear of sticky_ovf.

Function
REQ-019 Push: in_valid && in_ready at edge writes {in_a,in_b} at write pointer; in_ready = (count < DEPTH), no push when full.
REQ-020 add_a/add_b SHALL be combinationally driven from FIFO head when count > 0, else 32'h0 (bypass case per REQ-032).
REQ-021 Output slot free = !out_valid || out_ready.
REQ-022 Issue: count > 0 && slot free at edge -> capture add_result/add_ovf into out_result/out_ovf, set out_valid, pop head.
REQ-023 Slot free and no issue -> out_valid clears at edge; out_result/out_ovf hold last value.
REQ-024 out_valid && !out_ready -> out_result, out_ovf, out_valid SHALL hold stable.
REQ-025 Simultaneous push and pop -> count unchanged; both pointers advance.
REQ-026 Pointers log2(DEPTH) bits, wrap DEPTH-1 -> 0; count never exceeds DEPTH or underflows.
REQ-027 Order preserved: results leave in operand arrival order; no drop, no duplicate.
REQ-028 sticky_ovf sets at any issue with add_ovf=1; clear_sticky clears it; simultaneous set and clear -> set wins.
REQ-029 Latency (no bypass): pair pushed at edge N into empty queue with free slot -> out_valid high after edge N+1; throughput one result per cycle.

Reset
REQ-030 rst_n low SHALL immediately force: pointers 0, count 0, out_valid 0, out_result 32'h0, out_ovf 0, sticky_ovf 0; in_ready 1 after release.
REQ-031 Reset mid-operation discards all queued pairs and the pending result; nothing emitted after release until new pushes.

Configuration
REQ-032 Macro FPU_SP_OPQ_BYPASS_EN defined: when count==0, in_valid and slot free, add_a/add_b SHALL be driven from in_a/in_b, result captured at the same edge without FIFO write (out_valid high after edge N, latency 1); macro undefined: every pair passes through FIFO, latency per REQ-029.

Verification
REQ-033 Single add: in_a=32'h3F800000, in_b=32'h3F800000, out_ready=1 -> out_result=32'h40000000, out_ovf=0, out_valid after edge N+1 (N with bypass).
REQ-034 Fill: out_ready=0, push 5 pairs with DEPTH=4 -> 1 issued into output slot, count=4, in_ready=0; then out_ready=1 -> 5 results in order, count returns to 0.
REQ-035 Overflow: in_a=in_b=32'h7F7FFFFF -> out_ovf=1, sticky_ovf=1; next 32'h3F800000+32'h3F800000 -> out_ovf=0, sticky_ovf stays 1; clear_sticky pulse -> 0.
REQ-036 Simultaneous push/pop at count=2 for 10 cycles -> count stays 2, pointers wrap, results match order.
REQ-037 Set/clear race: clear_sticky=1 on edge issuing add_ovf=1 -> sticky_ovf=1.
REQ-038 Assert rst_n=0 asynchronously with count=3 and out_valid=1 -> outputs zero before next edge; no stale results after release.

Source files
------------

// File: rtl/fpu_sp_opq_if.sv
// Handshake bundle for fpu_sp_operand_queue: upstream operand pairs, the
// external adder hookup, the registered result stream and status.
interface fpu_sp_opq_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_a;
  logic [31:0]   in_b;

  logic [31:0]   add_a;
  logic [31:0]   add_b;
  logic [31:0]   add_result;
  logic          add_ovf;

  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_result;
  logic          out_ovf;

  logic [CW-1:0] count;
  logic          sticky_ovf;
  logic          clear_sticky;

  // master: the environment around the queue (producer, adder, consumer)
  modport master (
    output in_valid, in_a, in_b, add_result, add_ovf, out_ready, clear_sticky,
    input  in_ready, add_a, add_b, out_valid, out_result, out_ovf, count, sticky_ovf
  );

  // slave: the operand queue itself
  modport slave (
    input  in_valid, in_a, in_b, add_result, add_ovf, out_ready, clear_sticky,
    output in_ready, add_a, add_b, out_valid, out_result, out_ovf, count, sticky_ovf
  );
endinterface

// File: rtl/fpu_sp_operand_queue.sv
// Operand-pair FIFO in front of a combinational single-precision adder, with a
// registered result slot and sticky overflow. FPU_SP_OPQ_BYPASS_EN: empty-queue bypass.
module fpu_sp_operand_queue #(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  fpu_sp_opq_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          out_valid_reg;
  logic [31:0]   out_result_reg;
  logic          out_ovf_reg;
  logic          sticky_reg;

  logic          not_empty;
  logic          slot_free;
  logic          fifo_issue;
  logic          bypass_issue;
  logic          issue;
  logic          push;

  assign not_empty  = (count_reg != '0);
  assign slot_free  = !out_valid_reg || bus.out_ready;
  assign fifo_issue = not_empty && slot_free;

`ifdef FPU_SP_OPQ_BYPASS_EN
  // An empty queue lets the incoming pair go straight to the adder.
  assign bypass_issue = !not_empty && bus.in_valid && slot_free;
`else
  assign bypass_issue = 1'b0;
`endif

  assign issue        = fifo_issue || bypass_issue;
  assign bus.in_ready = (count_reg < CW'(DEPTH));
  assign push         = bus.in_valid && bus.in_ready && !bypass_issue;

  always_comb begin
    bus.add_a = 32'h0;
    bus.add_b = 32'h0;
    if (not_empty) begin
      bus.add_a = mem[rd_ptr_reg][63:32];
      bus.add_b = mem[rd_ptr_reg][31:0];
    end else if (bypass_issue) begin
      bus.add_a = bus.in_a;
      bus.add_b = bus.in_b;
    end
  end

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {bus.in_a, bus.in_b};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (fifo_issue) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push, fifo_issue})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Result slot: out_result/out_ovf only change on an issue, so they hold
  // both while stalled and after out_valid drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg  <= 1'b0;
      out_result_reg <= 32'h0;
      out_ovf_reg    <= 1'b0;
    end else if (issue) begin
      out_valid_reg  <= 1'b1;
      out_result_reg <= bus.add_result;
      out_ovf_reg    <= bus.add_ovf;
    end else if (slot_free) begin
      out_valid_reg  <= 1'b0;
    end
  end

  // A new overflow in the same cycle as a clear must not be lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_reg <= 1'b0;
    end else if (issue && bus.add_ovf) begin
      sticky_reg <= 1'b1;
    end else if (bus.clear_sticky) begin
      sticky_reg <= 1'b0;
    end
  end

  assign bus.out_valid  = out_valid_reg;
  assign bus.out_result = out_result_reg;
  assign bus.out_ovf    = out_ovf_reg;
  assign bus.count      = count_reg;
  assign bus.sticky_ovf = sticky_reg;
endmodule

// File: tb/tb_fpu_sp_operand_queue.sv
// Randomized bench for fpu_sp_operand_queue: a queue-based reference model
// plus a behavioural adder stub driving add_result/add_ovf.
module tb_fpu_sp_operand_queue;
  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;

  fpu_sp_opq_if #(.DEPTH(DEPTH)) bus ();

  fpu_sp_operand_queue #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;
  int n_out    = 0;

  // reference model state
  logic [63:0] q[$];
  bit          m_valid;
  logic [31:0] m_res;
  bit          m_ovf;
  bit          m_sticky;

  function automatic real sp2real(input logic [31:0] x);
    logic [63:0] d;
    if (x[30:23] == 8'h0) return 0.0;
    d = {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'h0};
    return $bitstoreal(d);
  endfunction

  // Adder stub: add in double precision, truncate back to single; flag an
  // exponent beyond single range (overflow) or a nonzero below it (underflow).
  function automatic logic [32:0] fadd(input logic [31:0] a, input logic [31:0] b);
    real         rs;
    logic [63:0] d;
    int          e;
    rs = sp2real(a) + sp2real(b);
    d  = $realtobits(rs);
    if (d[62:52] == 11'h0) return {1'b0, d[63], 31'h0};
    e = int'(d[62:52]) - 896;
    if (e >= 255) return {1'b1, d[63], 8'hFF, 23'h0};
    if (e <= 0)   return {1'b1, d[63], 31'h0};
    return {1'b0, d[63], e[7:0], d[51:29]};
  endfunction

  logic [32:0] sum_w;
  always_comb sum_w = fadd(bus.add_a, bus.add_b);
  assign bus.add_result = sum_w[31:0];
  assign bus.add_ovf    = sum_w[32];

  function automatic logic [31:0] rand_sp();
    return {1'($urandom), 8'($urandom_range(254, 1)), 23'($urandom)};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_state();
    check("count", 32'(bus.count), 32'(q.size()));
    check("in_ready", 32'(bus.in_ready), 32'(q.size() < DEPTH));
    check("out_valid", 32'(bus.out_valid), 32'(m_valid));
    check("out_result", bus.out_result, m_res);
    check("out_ovf", 32'(bus.out_ovf), 32'(m_ovf));
    check("sticky_ovf", 32'(bus.sticky_ovf), 32'(m_sticky));
    if (q.size() > 0) begin
      check("add_a", bus.add_a, q[0][63:32]);
      check("add_b", bus.add_b, q[0][31:0]);
    end
  endtask

  // One clock: drive inputs, advance the model across the edge, then compare.
  task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic ordy, input logic clr);
    bit          slot_free, from_fifo, byp, push, issue;
    logic [32:0] r;
    logic [63:0] p;
    bus.in_valid = v;
    bus.in_a = a;
    bus.in_b = b;
    bus.out_ready = ordy;
    bus.clear_sticky = clr;
    slot_free = !m_valid || ordy;
    from_fifo = (q.size() > 0) && slot_free;
    byp = 1'b0;
`ifdef FPU_SP_OPQ_BYPASS_EN
    byp = (q.size() == 0) && v && slot_free;
`endif
    push  = v && (q.size() < DEPTH) && !byp;
    issue = from_fifo || byp;
    r = '0;
    if (m_valid && ordy) begin
      $display("result #%0d: %h ovf=%0b", n_out, m_res, m_ovf);
      n_out++;
    end
    if (from_fifo) begin
      p = q.pop_front();
      r = fadd(p[63:32], p[31:0]);
    end else if (byp) begin
      r = fadd(a, b);
    end
    @(posedge clk);
    if (issue) begin
      m_valid = 1'b1;
      m_res   = r[31:0];
      m_ovf   = r[32];
    end else if (slot_free) begin
      m_valid = 1'b0;
    end
    if (issue && r[32]) m_sticky = 1'b1;
    else if (clr)       m_sticky = 1'b0;
    if (push) q.push_back({a, b});
    @(negedge clk);
    check_state();
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (q.size() > 0 || m_valid); i++) begin
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    end
    check("drain_count", 32'(bus.count), 32'h0);
    check("drain_valid", 32'(bus.out_valid), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_a = 32'h0;
    bus.in_b = 32'h0;
    bus.out_ready = 1'b0;
    bus.clear_sticky = 1'b0;
    m_valid = 1'b0;
    m_res = 32'h0;
    m_ovf = 1'b0;
    m_sticky = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_state();

    // single add 1.0 + 1.0
    cycle(1'b1, 32'h3F800000, 32'h3F800000, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("single_sum", bus.out_result, 32'h40000000);
    check("single_ovf", 32'(bus.out_ovf), 32'h0);
    drain();

    // fill with consumer stalled, then release
    for (int i = 0; i < 5; i++) cycle(1'b1, rand_sp(), rand_sp(), 1'b0, 1'b0);
    check("fill_count", 32'(bus.count), 32'd4);
    check("fill_in_ready", 32'(bus.in_ready), 32'h0);
    check("fill_out_valid", 32'(bus.out_valid), 32'h1);
    drain();

    // overflow, then normal add, then clear
    cycle(1'b1, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("ovf_flag", 32'(bus.out_ovf), 32'h1);
    check("ovf_sticky", 32'(bus.sticky_ovf), 32'h1);
    cycle(1'b1, 32'h3F800000, 32'h3F800000, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("ovf_next_flag", 32'(bus.out_ovf), 32'h0);
    check("ovf_sticky_hold", 32'(bus.sticky_ovf), 32'h1);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    check("sticky_clear", 32'(bus.sticky_ovf), 32'h0);
    drain();

    // set/clear race: clear asserted on the edge that issues an overflow
    cycle(1'b1, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    check("race_sticky", 32'(bus.sticky_ovf), 32'h1);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    drain();

    // steady state at count 2 with push and pop every cycle
    for (int i = 0; i < 3; i++) cycle(1'b1, rand_sp(), rand_sp(), 1'b0, 1'b0);
    check("steady_start", 32'(bus.count), 32'd2);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, rand_sp(), rand_sp(), 1'b1, 1'b0);
      check("steady_count", 32'(bus.count), 32'd2);
    end
    drain();

    // random traffic
    for (int i = 0; i < 300; i++) begin
      cycle(1'(($urandom % 4) != 0), rand_sp(), rand_sp(),
            1'(($urandom % 3) != 0), 1'(($urandom % 16) == 0));
    end
    drain();

    // asynchronous reset with count 3 and a pending result
    for (int i = 0; i < 4; i++) cycle(1'b1, rand_sp(), rand_sp(), 1'b0, 1'b0);
    check("pre_reset_count", 32'(bus.count), 32'd3);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_count", 32'(bus.count), 32'h0);
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_out_result", bus.out_result, 32'h0);
    check("rst_out_ovf", 32'(bus.out_ovf), 32'h0);
    check("rst_sticky", 32'(bus.sticky_ovf), 32'h0);
    q.delete();
    m_valid = 1'b0;
    m_res = 32'h0;
    m_ovf = 1'b0;
    m_sticky = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("post_reset_in_ready", 32'(bus.in_ready), 32'h1);
    cycle(1'b1, 32'h3F800000, 32'h3F800000, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("post_reset_sum", bus.out_result, 32'h40000000);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
